// File: rtl/ed25519_pkg.sv
// Shared edwards25519 definitions: field constants, extended point type
// and the scalar-multiplication controller state encoding.
package ed25519_pkg;

   localparam int WIDTH = 255;

   // Field prime 2^255 - 19 (all ones minus 18).
   localparam logic [WIDTH-1:0] P_MOD = ~255'd18;

   // Montgomery form of 1: R mod p with R = 2^255.
   localparam logic [WIDTH-1:0] ONE_M = 255'h13;

   // Neutral element in extended coordinates, Montgomery domain.
   localparam logic [WIDTH-1:0] ID_X = 255'h0;
   localparam logic [WIDTH-1:0] ID_Y = ONE_M;
   localparam logic [WIDTH-1:0] ID_Z = ONE_M;
   localparam logic [WIDTH-1:0] ID_T = 255'h0;

   typedef struct packed {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic [WIDTH-1:0] z;
      logic [WIDTH-1:0] t;
   } ext_point_t;

   localparam ext_point_t ZERO_PT = {ID_X, ID_X, ID_X, ID_X};
   localparam ext_point_t ID_PT   = {ID_X, ID_Y, ID_Z, ID_T};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_INIT_W = 3'd2,
      S_DBL    = 3'd3,
      S_DBL_W  = 3'd4,
      S_ADD    = 3'd5,
      S_ADD_W  = 3'd6,
      S_DONE   = 3'd7
   } sm_state_t;

   // States in which a PointAdd operation is launched.
   function automatic logic is_issue_state(input sm_state_t s);
      case (s)
         S_INIT, S_DBL, S_ADD: return 1'b1;
         default:              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/scalar_mult_ctrl.sv
// Constant-time double-and-always-add sequencer computing Q = k*P through
// the shared PointAdd unit. Every output is a register loaded from the
// next-state values, so operands are stable for the whole issue/wait window.
module scalar_mult_ctrl #(
   parameter int WIDTH       = 255,
   parameter int SCALAR_BITS = 255
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic [SCALAR_BITS-1:0] i_k,
   input  logic [WIDTH-1:0]       i_px,
   input  logic [WIDTH-1:0]       i_py,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [WIDTH-1:0]       o_qx,
   output logic [WIDTH-1:0]       o_qy,
   output logic [WIDTH-1:0]       o_qz,
   output logic [WIDTH-1:0]       o_qt,
   output logic                   o_pa_start,
   output logic                   o_pa_doubling,
   output logic                   o_pa_initial,
   output logic [WIDTH-1:0]       o_pa_x1,
   output logic [WIDTH-1:0]       o_pa_y1,
   output logic [WIDTH-1:0]       o_pa_z1,
   output logic [WIDTH-1:0]       o_pa_t1,
   output logic [WIDTH-1:0]       o_pa_x2,
   output logic [WIDTH-1:0]       o_pa_y2,
   output logic [WIDTH-1:0]       o_pa_z2,
   output logic [WIDTH-1:0]       o_pa_t2,
   input  logic                   i_pa_finished,
   input  logic [WIDTH-1:0]       i_pa_x3,
   input  logic [WIDTH-1:0]       i_pa_y3,
   input  logic [WIDTH-1:0]       i_pa_z3,
   input  logic [WIDTH-1:0]       i_pa_t3
);
   import ed25519_pkg::*;

   localparam int IDX_W = (SCALAR_BITS > 1) ? $clog2(SCALAR_BITS) : 1;

   sm_state_t              r_state;
   ext_point_t             r_acc;
   ext_point_t             r_base;
   logic [SCALAR_BITS-1:0] r_k;
   logic [IDX_W-1:0]       r_idx;
   ext_point_t             r_q;
   ext_point_t             r_op1;
   ext_point_t             r_op2;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_pa_start;
   logic                   r_pa_doubling;
   logic                   r_pa_initial;

   sm_state_t              w_state_nxt;
   ext_point_t             w_acc_nxt;
   ext_point_t             w_base_nxt;
   logic [SCALAR_BITS-1:0] w_k_nxt;
   logic [IDX_W-1:0]       w_idx_nxt;
   ext_point_t             w_op1_nxt;
   ext_point_t             w_op2_nxt;
   ext_point_t             w_pa_res;

   // The Z coordinate (i_pa_z3) only matters for accumulator updates; the
   // base point always has its Z forced to ONE_M after initial conversion.
   assign w_pa_res = {i_pa_x3, i_pa_y3, i_pa_z3, i_pa_t3};

   // Next-state, accumulator, base and bit-counter decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_base_nxt  = r_base;
      w_k_nxt     = r_k;
      w_idx_nxt   = r_idx;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_k_nxt     = i_k;
               w_base_nxt  = {i_px, i_py, ID_X, ID_X};
               w_acc_nxt   = ID_PT;
               w_idx_nxt   = IDX_W'(SCALAR_BITS - 1);
               w_state_nxt = S_INIT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_INIT: w_state_nxt = S_INIT_W;
         S_INIT_W: begin
            if (i_pa_finished) begin
               w_base_nxt  = {i_pa_x3, i_pa_y3, ONE_M, i_pa_t3};
               w_state_nxt = S_DBL;
            end else begin
               w_state_nxt = S_INIT_W;
            end
         end
         S_DBL: w_state_nxt = S_DBL_W;
         S_DBL_W: begin
            if (i_pa_finished) begin
               w_acc_nxt   = w_pa_res;
               w_state_nxt = S_ADD;
            end else begin
               w_state_nxt = S_DBL_W;
            end
         end
         S_ADD: w_state_nxt = S_ADD_W;
         S_ADD_W: begin
            if (i_pa_finished) begin
               // The add is always performed; a zero bit just drops its result.
               if (r_k[r_idx]) begin
                  w_acc_nxt = w_pa_res;
               end else begin
                  w_acc_nxt = r_acc;
               end
               if (r_idx == IDX_W'(0)) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_idx_nxt   = r_idx - IDX_W'(1);
                  w_state_nxt = S_DBL;
               end
            end else begin
               w_state_nxt = S_ADD_W;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand buses for the state being entered; zero outside issue/wait.
   always_comb begin
      w_op1_nxt = ZERO_PT;
      w_op2_nxt = ZERO_PT;
      case (w_state_nxt)
         S_INIT, S_INIT_W: begin
            w_op1_nxt.x = w_base_nxt.x;
            w_op1_nxt.y = w_base_nxt.y;
         end
         S_DBL, S_DBL_W: begin
            w_op1_nxt = w_acc_nxt;
            w_op2_nxt = w_acc_nxt;
         end
         S_ADD, S_ADD_W: begin
            w_op1_nxt = w_acc_nxt;
            w_op2_nxt = w_base_nxt;
         end
         default: begin
            w_op1_nxt = ZERO_PT;
            w_op2_nxt = ZERO_PT;
         end
      endcase
   end

   // State, datapath registers and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_acc         <= ZERO_PT;
         r_base        <= ZERO_PT;
         r_k           <= {SCALAR_BITS{1'b0}};
         r_idx         <= {IDX_W{1'b0}};
         r_q           <= ZERO_PT;
         r_op1         <= ZERO_PT;
         r_op2         <= ZERO_PT;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_pa_start    <= 1'b0;
         r_pa_doubling <= 1'b0;
         r_pa_initial  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_acc         <= w_acc_nxt;
         r_base        <= w_base_nxt;
         r_k           <= w_k_nxt;
         r_idx         <= w_idx_nxt;
         r_op1         <= w_op1_nxt;
         r_op2         <= w_op2_nxt;
         r_busy        <= (w_state_nxt != S_IDLE);
         r_done        <= (w_state_nxt == S_DONE);
         r_pa_start    <= is_issue_state(w_state_nxt);
         r_pa_doubling <= (w_state_nxt == S_DBL);
         r_pa_initial  <= (w_state_nxt == S_INIT);
         if (w_state_nxt == S_DONE) begin
            r_q <= w_acc_nxt;
         end
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_qx          = r_q.x;
   assign o_qy          = r_q.y;
   assign o_qz          = r_q.z;
   assign o_qt          = r_q.t;
   assign o_pa_start    = r_pa_start;
   assign o_pa_doubling = r_pa_doubling;
   assign o_pa_initial  = r_pa_initial;
   assign o_pa_x1       = r_op1.x;
   assign o_pa_y1       = r_op1.y;
   assign o_pa_z1       = r_op1.z;
   assign o_pa_t1       = r_op1.t;
   assign o_pa_x2       = r_op2.x;
   assign o_pa_y2       = r_op2.y;
   assign o_pa_z2       = r_op2.z;
   assign o_pa_t2       = r_op2.t;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl. PointAdd is replaced by a fixed-latency mock
// that implements an additive group on field elements (x, t add; y, z add
// around ONE), so k*P has a closed form computable with plain modular
// multiplication and a wrong double/add/dummy decision shows up in Q.
module tb_scalar_mult_ctrl;
   localparam int W      = 255;
   localparam int SB     = 255;
   localparam int D      = 4;
   localparam int NOPS   = 1 + 2 * SB;
   localparam int LAT    = NOPS * (D + 1) + 1;
   localparam int BUDGET = LAT + 200;
   localparam logic [W-1:0] PM     = ~255'd18;
   localparam logic [W-1:0] ONE    = 255'h13;
   localparam logic [W-1:0] ZW     = 255'h0;
   localparam logic [W-1:0] GARB_Z = 255'h5A5A;
   localparam logic [W-1:0] GARB   = 255'hDEAD_BEEF_0BAD_F00D;

   typedef struct packed {
      logic [W-1:0] x, y, z, t;
   } pt_t;

   typedef struct packed {
      logic [W-1:0] k, px, py, qx, qy, qz, qt;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, inj_fin;
   logic [W-1:0] k, px, py;
   logic busy, done, pa_start, pa_dbl, pa_init, pa_fin;
   logic [W-1:0] qx, qy, qz, qt;
   logic [W-1:0] x1, y1, z1, t1, x2, y2, z2, t2, x3, y3, z3, t3;

   pt_t  m_res, l1, l2;
   logic m_fin, l_init;
   int   m_rem   = 0;
   int   op_cnt  = 0;
   int   stab_err = 0;
   int   ovl_err = 0;
   logic [1:0] seq [1024];

   int checks = 0;
   int errors = 0;

   pt_t w_op1, w_op2;
   assign w_op1  = {x1, y1, z1, t1};
   assign w_op2  = {x2, y2, z2, t2};
   assign pa_fin = m_fin | inj_fin;
   assign x3 = inj_fin ? GARB : m_res.x;
   assign y3 = inj_fin ? GARB : m_res.y;
   assign z3 = inj_fin ? GARB : m_res.z;
   assign t3 = inj_fin ? GARB : m_res.t;

   scalar_mult_ctrl #(.WIDTH(W), .SCALAR_BITS(SB)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_k(k), .i_px(px), .i_py(py),
      .o_busy(busy), .o_done(done), .o_qx(qx), .o_qy(qy), .o_qz(qz), .o_qt(qt),
      .o_pa_start(pa_start), .o_pa_doubling(pa_dbl), .o_pa_initial(pa_init),
      .o_pa_x1(x1), .o_pa_y1(y1), .o_pa_z1(z1), .o_pa_t1(t1),
      .o_pa_x2(x2), .o_pa_y2(y2), .o_pa_z2(z2), .o_pa_t2(t2),
      .i_pa_finished(pa_fin),
      .i_pa_x3(x3), .i_pa_y3(y3), .i_pa_z3(z3), .i_pa_t3(t3)
   );

   function automatic logic [W-1:0] addm(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, PM}) s = s - {1'b0, PM};
      return s[W-1:0];
   endfunction

   function automatic logic [W-1:0] subm(input logic [W-1:0] a, input logic [W-1:0] b);
      return addm(a, (b == ZW) ? ZW : (PM - b));
   endfunction

   function automatic logic [W-1:0] mulm(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] pr;
      pr = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, PM};
      return pr[W-1:0];
   endfunction

   function automatic logic [W-1:0] rnd_w(input bit reduce);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
      if (reduce && (r[W-1:0] >= PM)) return r[W-1:0] - PM;
      return r[W-1:0];
   endfunction

   // Closed-form k*P in the mock group (P.z forced to ONE by the controller).
   function automatic vec_t mk_vec(input logic [W-1:0] rk, input logic [W-1:0] rpx,
                                   input logic [W-1:0] rpy);
      vec_t v;
      v.k  = rk;  v.px = rpx;  v.py = rpy;
      v.qx = mulm(rk, rpx);
      v.qy = addm(ONE, mulm(rk, subm(rpy, ONE)));
      v.qz = ONE;
      v.qt = mulm(rk, addm(rpx, rpy));
      return v;
   endfunction

   // Mock PointAdd: latches operands on start, answers D cycles later.
   always @(posedge clk) begin
      if (rst) begin
         m_rem <= 0;
         m_fin <= 1'b0;
      end else begin
         m_fin <= 1'b0;
         if (pa_start) begin
            if (m_rem != 0) ovl_err <= ovl_err + 1;
            m_rem  <= D - 1;
            l1     <= w_op1;
            l2     <= w_op2;
            l_init <= pa_init;
            seq[op_cnt % 1024] <= {pa_init, pa_dbl};
            op_cnt <= op_cnt + 1;
         end else if (m_rem != 0) begin
            if (w_op1 !== l1 || w_op2 !== l2) stab_err <= stab_err + 1;
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_fin <= 1'b1;
               if (l_init) begin
                  m_res.x <= l1.x;
                  m_res.y <= l1.y;
                  m_res.z <= GARB_Z;
                  m_res.t <= addm(l1.x, l1.y);
               end else begin
                  m_res.x <= addm(l1.x, l2.x);
                  m_res.y <= subm(addm(l1.y, l2.y), ONE);
                  m_res.z <= subm(addm(l1.z, l2.z), ONE);
                  m_res.t <= addm(l1.t, l2.t);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] op_or();
      return x1 | y1 | z1 | t1 | x2 | y2 | z2 | t2;
   endfunction

   // One run. mode 0 plain, 1 extra i_start pulses, 2 spurious finish in
   // S_DBL, 3 reset at cycle 1000. Cycle 1 is the cycle after acceptance.
   task automatic do_run(input logic [W-1:0] rk, input logic [W-1:0] rpx,
                         input logic [W-1:0] rpy, input int mode,
                         output int dcyc, output int nops, output int busy_bad,
                         output int seq_bad);
      int c, base;
      bit seen, spur;
      @(negedge clk);
      k = rk; px = rpx; py = rpy; start = 1'b1;
      base = op_cnt;
      c = 0; seen = 1'b0; spur = 1'b0; dcyc = -1; busy_bad = 0; seq_bad = 0;
      while (!seen && c < BUDGET) begin
         @(negedge clk);
         c++;
         start   = 1'b0;
         inj_fin = 1'b0;
         if (busy !== 1'b1) busy_bad++;
         if (done === 1'b1) begin
            seen = 1'b1;
            dcyc = c;
         end else begin
            if (mode == 1 && (c == 10 || c == 500)) begin
               start = 1'b1; k = ~rk; px = addm(rpx, ONE); py = addm(rpy, ONE);
            end
            if (mode == 2 && !spur && pa_start && pa_dbl) begin
               inj_fin = 1'b1; spur = 1'b1;
            end
            if (mode == 3 && c == 1000) begin
               rst = 1'b1;
               break;
            end
         end
      end
      nops = op_cnt - base;
      for (int j = 0; j < nops && j < 1024; j++) begin
         if (seq[(base + j) % 1024] !== ((j == 0) ? 2'b10 : ((j % 2 == 1) ? 2'b01 : 2'b00)))
            seq_bad++;
      end
   endtask

   vec_t vt [7];
   vec_t v;
   int dcyc, nops, bb, sb;

   initial begin
      rst = 1'b1; start = 1'b0; inj_fin = 1'b0;
      k = ZW; px = ZW; py = ZW;

      vt[0] = mk_vec(255'h0, rnd_w(1'b1), rnd_w(1'b1));
      vt[1] = mk_vec(255'h1, rnd_w(1'b1), rnd_w(1'b1));
      vt[2] = mk_vec(255'h2, rnd_w(1'b1), rnd_w(1'b1));
      vt[3] = mk_vec(~255'h0, rnd_w(1'b1), rnd_w(1'b1));
      for (int i = 4; i < 7; i++) vt[i] = mk_vec(rnd_w(1'b0), rnd_w(1'b1), rnd_w(1'b1));

      repeat (3) @(negedge clk);
      chk("reset_busy", {254'h0, busy}, ZW);
      chk("reset_done", {254'h0, done}, ZW);
      chk("reset_pa_ctl", {252'h0, pa_start, pa_dbl, pa_init}, ZW);
      chk("reset_opnd", op_or(), ZW);
      chk("reset_q", qx | qy | qz | qt, ZW);
      rst = 1'b0;

      // Table-driven full runs.
      for (int i = 0; i < 7; i++) begin
         do_run(vt[i].k, vt[i].px, vt[i].py, 0, dcyc, nops, bb, sb);
         chk($sformatf("v%0d_latency", i), W'(dcyc), W'(LAT));
         chk($sformatf("v%0d_nops", i), W'(nops), W'(NOPS));
         chk($sformatf("v%0d_dbl_seq_bad", i), W'(sb), ZW);
         chk($sformatf("v%0d_busy_low", i), W'(bb), ZW);
         chk($sformatf("v%0d_qx", i), qx, vt[i].qx);
         chk($sformatf("v%0d_qy", i), qy, vt[i].qy);
         chk($sformatf("v%0d_qz", i), qz, vt[i].qz);
         chk($sformatf("v%0d_qt", i), qt, vt[i].qt);
         @(negedge clk);
         chk($sformatf("v%0d_idle_ctl", i), {252'h0, busy, done, pa_start, pa_dbl | pa_init}, ZW);
         chk($sformatf("v%0d_idle_opnd", i), op_or(), ZW);
         chk($sformatf("v%0d_q_held", i), qx, vt[i].qx);
      end

      // i_start while busy must not disturb the captured operands.
      v = mk_vec(rnd_w(1'b0), rnd_w(1'b1), rnd_w(1'b1));
      do_run(v.k, v.px, v.py, 1, dcyc, nops, bb, sb);
      chk("restart_latency", W'(dcyc), W'(LAT));
      chk("restart_qx", qx, v.qx);
      chk("restart_qy", qy, v.qy);
      chk("restart_qt", qt, v.qt);

      // Spurious finish during the doubling issue cycle.
      v = mk_vec(rnd_w(1'b0), rnd_w(1'b1), rnd_w(1'b1));
      do_run(v.k, v.px, v.py, 2, dcyc, nops, bb, sb);
      chk("spur_dbl_latency", W'(dcyc), W'(LAT));
      chk("spur_dbl_nops", W'(nops), W'(NOPS));
      chk("spur_dbl_qx", qx, v.qx);
      chk("spur_dbl_qt", qt, v.qt);

      // Spurious finish while idle.
      @(negedge clk); inj_fin = 1'b1;
      @(negedge clk); inj_fin = 1'b0;
      @(negedge clk);
      chk("spur_idle_busy", {254'h0, busy}, ZW);
      chk("spur_idle_start", {254'h0, pa_start}, ZW);
      chk("spur_idle_q", qx, v.qx);

      // Reset in mid-run, then a fresh run.
      v = mk_vec(rnd_w(1'b0), rnd_w(1'b1), rnd_w(1'b1));
      do_run(v.k, v.px, v.py, 3, dcyc, nops, bb, sb);
      @(negedge clk);
      chk("midrst_ctl", {251'h0, busy, done, pa_start, pa_dbl, pa_init}, ZW);
      chk("midrst_opnd", op_or(), ZW);
      chk("midrst_q", qx | qy | qz | qt, ZW);
      rst = 1'b0;
      do_run(v.k, v.px, v.py, 0, dcyc, nops, bb, sb);
      chk("post_rst_latency", W'(dcyc), W'(LAT));
      chk("post_rst_qx", qx, v.qx);
      chk("post_rst_qy", qy, v.qy);
      chk("post_rst_qz", qz, v.qz);
      chk("post_rst_qt", qt, v.qt);

      chk("operand_stability", W'(stab_err), ZW);
      chk("start_overlap", W'(ovl_err), ZW);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
